// File: rtl/video_composite_timing_pkg.sv
// rtl/video_composite_timing_pkg.sv - NTSC timing constants and half-line classes for video_composite_timing
package video_composite_timing_pkg;

    localparam logic [10:0] H_TOTAL        = 11'd1588;
    localparam logic [10:0] HALF           = 11'd794;
    localparam logic [10:0] HSYNC_W        = 11'd117;
    localparam logic [10:0] EQ_W           = 11'd58;
    localparam logic [10:0] BURST_START    = 11'd133;
    localparam logic [10:0] BURST_W        = 11'd63;
    localparam logic [10:0] ACTIVE_START   = 11'd272;
    localparam logic [10:0] ACTIVE_W       = 11'd1280;
    localparam logic [8:0]  V_ACTIVE_FIRST = 9'd21;
    localparam logic [8:0]  V_ACTIVE_LINES = 9'd240;

    localparam logic [10:0] FIELD_HALFLINES = 11'd525;
    localparam logic [8:0]  FIELD_LINES     = 9'd262;
    localparam logic [10:0] PROG_HL_LAST    = 11'd523;
    localparam logic [10:0] INTL_HL_LAST    = 11'd1049;

    typedef enum logic [1:0] {
        HL_EQ_PRE,
        HL_BROAD,
        HL_EQ_POST,
        HL_NORMAL
    } hl_class_e;

    function automatic hl_class_e classify_halfline(input logic [9:0] f);
        if (f < 10'd6)       return HL_EQ_PRE;
        else if (f < 10'd12) return HL_BROAD;
        else if (f < 10'd18) return HL_EQ_POST;
        else                 return HL_NORMAL;
    endfunction

endpackage

// File: rtl/video_composite_timing_halfline_counter.sv
// rtl/video_composite_timing_halfline_counter.sv - clock and half-line counters; VIDEO_COMPOSITE_INTERLACE_EN adds the second field
module video_halfline_counter
    import video_composite_timing_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [10:0] h_o,
    output logic [10:0] hl_o,
    output logic        field_o,
    output logic [10:0] hh_o,
    output logic [9:0]  f_o,
    output logic [8:0]  fl_o
);

`ifdef VIDEO_COMPOSITE_INTERLACE_EN
    localparam logic [10:0] HL_LAST = INTL_HL_LAST;
`else
    localparam logic [10:0] HL_LAST = PROG_HL_LAST;
`endif

    logic [10:0] h_q, h_d;
    logic [10:0] hl_q, hl_d;

    always_comb begin
        h_d  = h_q;
        hl_d = hl_q;
        if (!enable) begin
            h_d  = 11'd0;
            hl_d = 11'd0;
        end else begin
            h_d = (h_q == H_TOTAL - 11'd1) ? 11'd0 : h_q + 11'd1;
            if (h_q == HALF - 11'd1 || h_q == H_TOTAL - 11'd1)
                hl_d = (hl_q == HL_LAST) ? 11'd0 : hl_q + 11'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q  <= 11'd0;
            hl_q <= 11'd0;
        end else begin
            h_q  <= h_d;
            hl_q <= hl_d;
        end
    end

`ifdef VIDEO_COMPOSITE_INTERLACE_EN
    assign field_o = (hl_q >= FIELD_HALFLINES);
`else
    assign field_o = 1'b0;
`endif

    // Field-relative values wrap modulo the output width, which is exact for the ranges reached.
    assign h_o  = h_q;
    assign hl_o = hl_q;
    assign hh_o = (h_q < HALF) ? h_q : h_q - HALF;
    assign f_o  = hl_q[9:0] - (field_o ? FIELD_HALFLINES[9:0] : 10'd0);
    assign fl_o = hl_q[9:1] - (field_o ? FIELD_LINES : 9'd0);

endmodule

// File: rtl/video_composite_timing.sv
// rtl/video_composite_timing.sv - NTSC composite sync/burst/active generator; VIDEO_COMPOSITE_INTERLACE_EN selects 525-line interlace
module video_composite_timing
    import video_composite_timing_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       sync_n,
    output logic       color_burst,
    output logic       active,
    output logic [9:0] x_pos,
    output logic [8:0] y_pos,
    output logic       line_start,
    output logic       frame_start,
    output logic       field
);

    logic [10:0] h, hl, hh;
    logic [9:0]  f;
    logic [8:0]  fl;
    logic        cur_field;

    video_halfline_counter u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .h_o     (h),
        .hl_o    (hl),
        .field_o (cur_field),
        .hh_o    (hh),
        .f_o     (f),
        .fl_o    (fl)
    );

    hl_class_e   hl_class;
    logic        sync_low, burst_d, act_d;
    logic [9:0]  x_d;
    logic [8:0]  y_rel, y_d;

    always_comb begin
        hl_class = classify_halfline(f);
        sync_low = 1'b0;
        unique case (hl_class)
            HL_EQ_PRE, HL_EQ_POST: sync_low = (hh < EQ_W);
            HL_BROAD:              sync_low = (hh < HALF - HSYNC_W);
            HL_NORMAL:             sync_low = (h < HSYNC_W);
            default:               sync_low = 1'b0;
        endcase
        burst_d = (hl_class == HL_NORMAL) && (h >= BURST_START) && (h < BURST_START + BURST_W);
        act_d   = (fl >= V_ACTIVE_FIRST) && (fl < V_ACTIVE_FIRST + V_ACTIVE_LINES)
               && (h >= ACTIVE_START) && (h < ACTIVE_START + ACTIVE_W);
        // ACTIVE_START is even, so halving before subtracting gives the same column.
        x_d   = act_d ? (h[10:1] - ACTIVE_START[10:1]) : 10'd0;
        y_rel = fl - V_ACTIVE_FIRST;
`ifdef VIDEO_COMPOSITE_INTERLACE_EN
        y_d = act_d ? ((y_rel << 1) | {8'd0, cur_field}) : 9'd0;
`else
        y_d = act_d ? y_rel : 9'd0;
`endif
    end

    logic       sync_n_q, burst_q, active_q, line_start_q, frame_start_q, field_q;
    logic [9:0] x_q;
    logic [8:0] y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_n_q      <= 1'b1;
            burst_q       <= 1'b0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            field_q       <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 9'd0;
        end else if (!enable) begin
            sync_n_q      <= 1'b1;
            burst_q       <= 1'b0;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            field_q       <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 9'd0;
        end else begin
            sync_n_q      <= ~sync_low;
            burst_q       <= burst_d;
            active_q      <= act_d;
            line_start_q  <= (h == 11'd0);
            frame_start_q <= (h == 11'd0) && (hl == 11'd0);
            field_q       <= cur_field;
            x_q           <= x_d;
            y_q           <= y_d;
        end
    end

    assign sync_n      = sync_n_q;
    assign color_burst = burst_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign field       = field_q;
    assign x_pos       = x_q;
    assign y_pos       = y_q;

endmodule
